// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and state type for the I2S responder endpoint.
//   SerialDataWidth - bits per word on the wire (MSB first)
//   SlotWidth       - sclk periods per half-frame
//   BitCountWidth   - width of the per-half-frame bit counter
// Optional build macro: I2S_LEFT_JUSTIFIED_EN selects left-justified framing
// (no delay slot, lrck high = left) instead of standard I2S.
package i2s_pkg;
    localparam int SerialDataWidth = 24;
    localparam int SlotWidth       = 32;
    localparam int BitCountWidth   = 5;
    localparam logic [BitCountWidth-1:0] BitCountMax = BitCountWidth'(SlotWidth - 1);

`ifdef I2S_LEFT_JUSTIFIED_EN
    // MSB sits in the first slot after the lrck change; lrck high marks left.
    localparam int   FirstBit  = 0;
    localparam logic LeftLevel = 1'b1;
`else
    // Standard I2S: one-bit delay slot after the lrck change; lrck low marks left.
    localparam int   FirstBit  = 1;
    localparam logic LeftLevel = 1'b0;
`endif

    typedef enum logic [1:0] {SYNC_S, LEFT_S, RIGHT_S} i2s_state_e;
endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: multi-flop synchronizer for one asynchronous input plus a
// history flop for edge detection.
//   clk, reset - system clock, synchronous active-high reset
//   din        - asynchronous input
//   level      - synchronized level
//   rise, fall - single-cycle pulses on synchronized 0->1 / 1->0
module i2s_sync_edge #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SyncStages-1:0] sync;
    logic                  hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SyncStages-2:0], din};
            hist <= sync[SyncStages-1];
        end
    end

    assign level = sync[SyncStages-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;
endmodule

// File: rtl/i2s_target.sv
// i2s_target: I2S responder (codec side). Follows an external sclk/lrck,
// deserializes stereo 24-bit words from sdin and serializes stereo words to
// sdout. All I2S inputs are asynchronous and synchronized onto clk.
//   clk, reset        - system clock, synchronous active-high reset
//   sclk, lrck, sdin  - external bit clock, word clock, serial data in
//   sdout             - serial data out, updated on sclk falling edges
//   rxLeft/rxRight    - received samples (24-bit word MSBs), rxValid pulse
//   txLeft/txRight    - samples to send, written to holding reg on txValid
//   txTaken           - pulse: holding register moved to the frame words
//   frameError        - pulse: half-frame was not exactly 32 sclk long
// Optional build macro: I2S_LEFT_JUSTIFIED_EN (left-justified framing).
module i2s_target
    import i2s_pkg::*;
#(
    parameter int DataWidth  = 12,
    parameter int SyncStages = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sclk,
    input  logic                        lrck,
    input  logic                        sdin,
    output logic                        sdout,
    output logic signed [DataWidth-1:0] rxLeft,
    output logic signed [DataWidth-1:0] rxRight,
    output logic                        rxValid,
    input  logic signed [DataWidth-1:0] txLeft,
    input  logic signed [DataWidth-1:0] txRight,
    input  logic                        txValid,
    output logic                        txTaken,
    output logic                        frameError
);
    localparam logic [BitCountWidth-1:0] RxFirst = BitCountWidth'(FirstBit);
    localparam logic [BitCountWidth-1:0] RxLen   = BitCountWidth'(DataWidth);
    localparam logic [BitCountWidth-1:0] RxDone  = BitCountWidth'(FirstBit + SerialDataWidth - 1);
    // Bits go out one fall ahead of the rise that samples them.
    localparam logic [BitCountWidth:0]   TxSkew  = (BitCountWidth+1)'(1 - FirstBit);
    localparam logic [BitCountWidth:0]   TxLen   = (BitCountWidth+1)'(SerialDataWidth);
    localparam int                       PadWidth = SerialDataWidth - DataWidth;

    logic sclk_q, sclk_rise, sclk_fall, lrck_q, sdin_q;
    logic lrck_rise, lrck_fall, sdin_rise, sdin_fall;
    logic unused_edges;

    i2s_state_e               state, state_next;
    logic                     lrck_last, overrun, lrck_change, half_ok;
    logic                     frame_err_next, load_tx;
    logic [BitCountWidth-1:0] bit_count, cur_count, rx_idx, tx_idx;
    logic [BitCountWidth:0]   tx_pos;
    logic                     rx_shift, rx_done, tx_bit;
    logic [DataWidth-1:0]     rx_sh_l, rx_sh_r, rx_sh_r_next;
    logic [DataWidth-1:0]     hold_l, hold_r, tx_l, tx_r;
    logic [SerialDataWidth-1:0] tx_word;

    // Identical synchronizers keep sclk, lrck and sdin aligned in time.
    i2s_sync_edge #(.SyncStages(SyncStages)) u_sclk (
        .clk(clk), .reset(reset), .din(sclk), .level(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    i2s_sync_edge #(.SyncStages(SyncStages)) u_lrck (
        .clk(clk), .reset(reset), .din(lrck), .level(lrck_q), .rise(lrck_rise), .fall(lrck_fall));
    i2s_sync_edge #(.SyncStages(SyncStages)) u_sdin (
        .clk(clk), .reset(reset), .din(sdin), .level(sdin_q), .rise(sdin_rise), .fall(sdin_fall));

    assign unused_edges = ^{sclk_q, lrck_rise, lrck_fall, sdin_rise, sdin_fall};

    assign lrck_change = sclk_rise && (lrck_q != lrck_last);
    // Saturation alone would hide an overlong half; overrun remembers it.
    assign half_ok     = (bit_count == BitCountMax) && !overrun;

    // Count index of the bit sampled at this rise.
    always_comb begin
        if (lrck_change)                 cur_count = '0;
        else if (bit_count == BitCountMax) cur_count = BitCountMax;
        else                             cur_count = bit_count + 1'b1;
    end

    always_comb begin
        state_next     = state;
        frame_err_next = 1'b0;
        if (lrck_change) begin
            case (state)
                SYNC_S:  if (lrck_q == LeftLevel) state_next = LEFT_S;
                LEFT_S:  if (half_ok) state_next = RIGHT_S;
                         else begin state_next = SYNC_S; frame_err_next = 1'b1; end
                RIGHT_S: if (half_ok) state_next = LEFT_S;
                         else begin state_next = SYNC_S; frame_err_next = 1'b1; end
                default: state_next = SYNC_S;
            endcase
        end
    end

    assign load_tx = (state_next == LEFT_S) && (state != LEFT_S);

    // Channel follows the post-transition state so that left-justified MSBs,
    // which arrive on the lrck-change rise itself, land in the new channel.
    assign rx_idx       = cur_count - RxFirst;
    assign rx_shift     = sclk_rise && (state_next != SYNC_S) && (rx_idx < RxLen);
    assign rx_done      = sclk_rise && (state_next == RIGHT_S) && (cur_count == RxDone);
    assign rx_sh_r_next = (rx_shift && state_next == RIGHT_S) ? {rx_sh_r[DataWidth-2:0], sdin_q} : rx_sh_r;

    always_comb begin
        tx_word = (state == LEFT_S) ? (SerialDataWidth'(tx_l) << PadWidth)
                                    : (SerialDataWidth'(tx_r) << PadWidth);
        tx_pos  = {1'b0, bit_count} + TxSkew;
        tx_idx  = BitCountWidth'(SerialDataWidth - 1) - tx_pos[BitCountWidth-1:0];
        tx_bit  = 1'b0;
        if (state != SYNC_S && tx_pos < TxLen) tx_bit = tx_word[tx_idx];
`ifdef I2S_LEFT_JUSTIFIED_EN
        // The MSB must be on the wire before the change rise samples it, i.e.
        // before the frame words are reloaded, so a new left word comes
        // straight from the holding register.
        if (lrck_q != lrck_last) begin
            if (lrck_q == LeftLevel)  tx_bit = hold_l[DataWidth-1];
            else if (state == LEFT_S) tx_bit = tx_r[DataWidth-1];
            else                      tx_bit = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC_S;
            lrck_last  <= 1'b0;
            bit_count  <= '0;
            overrun    <= 1'b0;
            rx_sh_l    <= '0;
            rx_sh_r    <= '0;
            rxLeft     <= '0;
            rxRight    <= '0;
            rxValid    <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            tx_l       <= '0;
            tx_r       <= '0;
            txTaken    <= 1'b0;
            frameError <= 1'b0;
            sdout      <= 1'b0;
        end else begin
            state      <= state_next;
            frameError <= frame_err_next;
            txTaken    <= load_tx;
            rxValid    <= rx_done;
            rx_sh_r    <= rx_sh_r_next;
            if (sclk_rise) begin
                lrck_last <= lrck_q;
                bit_count <= cur_count;
                overrun   <= !lrck_change && (bit_count == BitCountMax);
            end
            if (rx_shift && state_next == LEFT_S) rx_sh_l <= {rx_sh_l[DataWidth-2:0], sdin_q};
            if (rx_done) begin
                rxLeft  <= rx_sh_l;
                rxRight <= rx_sh_r_next;
            end
            // Transfer uses the holding value from before any same-cycle write.
            if (load_tx) begin
                tx_l <= hold_l;
                tx_r <= hold_r;
            end
            if (txValid) begin
                hold_l <= txLeft;
                hold_r <= txRight;
            end
            if (frame_err_next) sdout <= 1'b0;
            else if (sclk_fall) sdout <= tx_bit;
        end
    end
endmodule
